// File: rtl/mb_reconstruct_adder.sv
// Reconstruction adder: reads the completed prediction buffer, adds the IDCT residual,
// saturates to 0..255 and streams pixels with valid/ready on both sides.
module mb_reconstruct_adder #(
    parameter int   MB_PIXELS = 384,
    parameter logic BANK_INIT = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        Start_MB_Reconstruct_I,
    output logic        Done_MB_Reconstruct_O,
    input  logic        Intra_MB_I,
    input  logic [5:0]  Coded_Block_Pattern_I,
    output logic [10:0] Pred_Addr_O,
    input  logic [7:0]  Pred_Data_I,
    input  logic [8:0]  Residual_Data_I,
    input  logic        Residual_Valid_I,
    output logic        Residual_Ready_O,
    output logic [7:0]  Pixel_Data_O,
    output logic [2:0]  Pixel_Block_O,
    output logic [5:0]  Pixel_Index_O,
    output logic        Pixel_Last_O,
    output logic        Pixel_Valid_O,
    input  logic        Pixel_Ready_I
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [8:0]  p_q, p_d;
    logic        bank_q, bank_d;
    logic        intra_q, intra_d;
    logic [5:0]  cbp_q, cbp_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  blk_q, blk_d;
    logic [5:0]  idx_q, idx_d;
    logic        last_q, last_d;

    logic [7:0]        cbp_ext;
    logic              coded, out_free, fire, last_p;
    logic [7:0]        pred;
    logic [8:0]        res;
    logic signed [9:0] sum;
    logic [7:0]        sat;

    assign cbp_ext  = {2'b00, cbp_q};
    assign coded    = cbp_ext[p_q[8:6]];
    assign out_free = ~valid_q | Pixel_Ready_I;
    assign fire     = (state_q == RUN) & out_free & (~coded | Residual_Valid_I);
    assign last_p   = (p_q == 9'(MB_PIXELS - 1));

    // Uncoded blocks never pop the residual stream; their residual is zero.
    assign pred = intra_q ? 8'd0 : Pred_Data_I;
    assign res  = coded ? Residual_Data_I : 9'd0;
    assign sum  = $signed({2'b00, pred}) + $signed({res[8], res});
    assign sat  = sum[9] ? 8'd0 : (sum[8] ? 8'hFF : sum[7:0]);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            p_q     <= '0;
            bank_q  <= BANK_INIT;
            intra_q <= 1'b0;
            cbp_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            blk_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            bank_q  <= bank_d;
            intra_q <= intra_d;
            cbp_q   <= cbp_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        bank_d  = bank_q;
        intra_d = intra_q;
        cbp_d   = cbp_q;
        valid_d = valid_q;
        data_d  = data_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (Start_MB_Reconstruct_I) begin
                    state_d = PRIME;
                    intra_d = Intra_MB_I;
                    cbp_d   = Coded_Block_Pattern_I;
                    bank_d  = ~bank_q;
                    p_d     = '0;
                end
            end
            PRIME: state_d = RUN;
            RUN: begin
                if (fire) begin
                    p_d = p_q + 9'd1;
                    if (last_p) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (valid_q && Pixel_Ready_I) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fire) begin
            valid_d = 1'b1;
            data_d  = sat;
            blk_d   = p_q[8:6];
            idx_d   = p_q[5:0];
            last_d  = last_p;
        end else if (Pixel_Ready_I) begin
            valid_d = 1'b0;
        end
    end

    // Address runs one byte ahead on fire so the synchronous buffer returns p+1 next cycle.
    always_comb begin
        Done_MB_Reconstruct_O = (state_q == IDLE);
        Residual_Ready_O      = (state_q == RUN) & coded & out_free;
        if (state_q == IDLE)
            Pred_Addr_O = {~bank_q, 10'h000};
        else
            Pred_Addr_O = {bank_q, 1'b0, (fire ? p_q + 9'd1 : p_q)};
    end

    assign Pixel_Data_O  = data_q;
    assign Pixel_Block_O = blk_q;
    assign Pixel_Index_O = idx_q;
    assign Pixel_Last_O  = last_q;
    assign Pixel_Valid_O = valid_q;

endmodule

// File: tb/tb_mb_reconstruct_adder.sv
// Directed bench for mb_reconstruct_adder: buffer model, residual source and pixel sink
// around one linear stimulus sequence with hand-derived expectations.
module tb_mb_reconstruct_adder;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        Start_MB_Reconstruct_I = 1'b0;
    logic        Done_MB_Reconstruct_O;
    logic        Intra_MB_I = 1'b0;
    logic [5:0]  Coded_Block_Pattern_I = '0;
    logic [10:0] Pred_Addr_O;
    logic [7:0]  Pred_Data_I = '0;
    logic [8:0]  Residual_Data_I = '0;
    logic        Residual_Valid_I = 1'b0;
    logic        Residual_Ready_O;
    logic [7:0]  Pixel_Data_O;
    logic [2:0]  Pixel_Block_O;
    logic [5:0]  Pixel_Index_O;
    logic        Pixel_Last_O;
    logic        Pixel_Valid_O;
    logic        Pixel_Ready_I = 1'b1;

    mb_reconstruct_adder dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .Start_MB_Reconstruct_I (Start_MB_Reconstruct_I),
        .Done_MB_Reconstruct_O  (Done_MB_Reconstruct_O),
        .Intra_MB_I             (Intra_MB_I),
        .Coded_Block_Pattern_I  (Coded_Block_Pattern_I),
        .Pred_Addr_O            (Pred_Addr_O),
        .Pred_Data_I            (Pred_Data_I),
        .Residual_Data_I        (Residual_Data_I),
        .Residual_Valid_I       (Residual_Valid_I),
        .Residual_Ready_O       (Residual_Ready_O),
        .Pixel_Data_O           (Pixel_Data_O),
        .Pixel_Block_O          (Pixel_Block_O),
        .Pixel_Index_O          (Pixel_Index_O),
        .Pixel_Last_O           (Pixel_Last_O),
        .Pixel_Valid_O          (Pixel_Valid_O),
        .Pixel_Ready_I          (Pixel_Ready_I)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic [2:0] b;
        logic [5:0] i;
        logic       l;
    } pix_t;

    logic [7:0] mem [0:2047];
    logic [8:0] res_q [$];
    pix_t       got [$];
    int         exp_pix [384];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         rr_cnt = 0;
    int         addr_bad = 0;
    bit         gap_en = 1'b0;
    bit         mon_en = 1'b0;
    logic       mon_bank = 1'b0;

    always @(posedge clock) Pred_Data_I <= mem[Pred_Addr_O];

    always @(negedge clock) begin
        Residual_Valid_I = (res_q.size() != 0) && !(gap_en && (cyc % 3 == 1));
        Residual_Data_I  = (res_q.size() != 0) ? res_q[0] : 9'd0;
    end

    always @(posedge clock) begin
        pix_t t;
        cyc++;
        if (Residual_Ready_O) rr_cnt++;
        if (Residual_Valid_I && Residual_Ready_O) void'(res_q.pop_front());
        if (Pixel_Valid_O && Pixel_Ready_I) begin
            t.d = Pixel_Data_O; t.b = Pixel_Block_O; t.i = Pixel_Index_O; t.l = Pixel_Last_O;
            got.push_back(t);
        end
        if (mon_en && !Done_MB_Reconstruct_O && (Pred_Addr_O[10] !== mon_bank || Pred_Addr_O[9] !== 1'b0))
            addr_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        int s = a + b;
        return (s < 0) ? 0 : ((s > 255) ? 255 : s);
    endfunction

    task automatic do_start(input logic intra, input logic [5:0] cbp);
        @(negedge clock);
        Start_MB_Reconstruct_I = 1'b1;
        Intra_MB_I = intra;
        Coded_Block_Pattern_I = cbp;
        @(negedge clock);
        Start_MB_Reconstruct_I = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!Done_MB_Reconstruct_O && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk({tag, " done"}, Done_MB_Reconstruct_O, 1'b1);
    endtask

    task automatic check_mb(input string tag);
        int bad = 0;
        chk({tag, " count"}, got.size(), 384);
        for (int i = 0; i < got.size() && i < 384; i++) begin
            if (got[i].d !== 8'(exp_pix[i]) || got[i].b !== 3'(i >> 6) ||
                got[i].i !== 6'(i & 63) || got[i].l !== (i == 383))
                bad++;
        end
        chk({tag, " pixel errors"}, bad, 0);
    endtask

    initial begin
        logic [10:0] s_addr;
        logic [7:0]  s_data;
        logic [5:0]  s_idx;
        int k;

        for (int a = 0; a < 2048; a++) mem[a] = 8'h33;

        // Reset state
        @(negedge clock);
        chk("rst valid", Pixel_Valid_O, 1'b0);
        chk("rst done", Done_MB_Reconstruct_O, 1'b1);
        chk("rst rready", Residual_Ready_O, 1'b0);
        chk("rst data", {Pixel_Data_O, Pixel_Block_O, Pixel_Index_O, Pixel_Last_O}, 0);
        chk("rst addr", Pred_Addr_O, 11'h000);
        resetn = 1'b1;

        // T1: intra, all coded, residual +200, latency check
        for (int i = 0; i < 384; i++) begin res_q.push_back(9'd200); exp_pix[i] = 200; end
        got.delete();
        do_start(1'b1, 6'h3F);
        chk("T1 done low", Done_MB_Reconstruct_O, 1'b0);
        chk("T1 valid N", Pixel_Valid_O, 1'b0);
        @(negedge clock);
        chk("T1 valid N+1", Pixel_Valid_O, 1'b0);
        @(negedge clock);
        chk("T1 valid N+2", Pixel_Valid_O, 1'b1);
        chk("T1 first data", Pixel_Data_O, 8'd200);
        wait_done("T1");
        check_mb("T1");

        // T2: non-intra, uncoded, prediction 0x80; residuals present but untouched
        for (int a = 0; a < 2048; a++) mem[a] = 8'h80;
        for (int i = 0; i < 384; i++) exp_pix[i] = 128;
        for (int i = 0; i < 5; i++) res_q.push_back(9'h1AA);
        rr_cnt = 0;
        got.delete();
        do_start(1'b0, 6'h00);
        wait_done("T2");
        check_mb("T2");
        chk("T2 rready count", rr_cnt, 0);
        chk("T2 fifo untouched", res_q.size(), 5);
        res_q.delete();

        // T3: saturation corners in block 0 (bank 0)
        for (int a = 0; a < 384; a++) mem[a] = 8'h10;
        mem[0] = 8'd250; mem[1] = 8'd3; mem[2] = 8'd100; mem[3] = 8'd0; mem[4] = 8'd128;
        res_q.push_back(9'd10); res_q.push_back(9'h1F6); res_q.push_back(9'h100);
        res_q.push_back(9'd255); res_q.push_back(9'h1FF);
        for (int i = 5; i < 64; i++) res_q.push_back(9'd0);
        for (int i = 0; i < 384; i++) exp_pix[i] = 16;
        exp_pix[0] = 255; exp_pix[1] = 0; exp_pix[2] = 0; exp_pix[3] = 255; exp_pix[4] = 127;
        got.delete();
        do_start(1'b0, 6'h01);
        wait_done("T3");
        check_mb("T3");
        chk("T3 residuals consumed", res_q.size(), 0);

        // T4: backpressure at p=70 with gapped residuals (bank 1)
        for (int p = 0; p < 384; p++) begin
            mem[1024 + p] = 8'((p * 7) & 255);
            res_q.push_back(9'((p % 5) - 2));
            exp_pix[p] = sat_add((p * 7) & 255, (p % 5) - 2);
        end
        gap_en = 1'b1;
        got.delete();
        do_start(1'b0, 6'h3F);
        k = 0;
        while (!(Pixel_Valid_O && {Pixel_Block_O, Pixel_Index_O} == 9'd70) && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("T4 reach p70", {Pixel_Block_O, Pixel_Index_O}, 9'd70);
        Pixel_Ready_I = 1'b0;
        #1;
        s_addr = Pred_Addr_O; s_data = Pixel_Data_O; s_idx = Pixel_Index_O;
        chk("T4 stall addr", s_addr, {1'b1, 1'b0, 9'd71});
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            chk("T4 stall addr hold", Pred_Addr_O, s_addr);
            chk("T4 stall data hold", Pixel_Data_O, s_data);
            chk("T4 stall idx hold", Pixel_Index_O, s_idx);
            chk("T4 stall valid hold", Pixel_Valid_O, 1'b1);
        end
        Pixel_Ready_I = 1'b1;
        wait_done("T4");
        check_mb("T4");
        gap_en = 1'b0;

        // T5: three MBs back-to-back, bank alternation, Start during RUN ignored
        for (int p = 0; p < 384; p++) begin
            mem[p] = 8'(p);
            mem[1024 + p] = ~8'(p);
        end
        mon_en = 1'b1;
        for (int m = 0; m < 3; m++) begin
            mon_bank = m[0];
            addr_bad = 0;
            for (int p = 0; p < 384; p++) exp_pix[p] = m[0] ? (255 - (p & 255)) : (p & 255);
            got.delete();
            do_start(1'b0, 6'h00);
            if (m == 0) begin
                repeat (50) @(negedge clock);
                Start_MB_Reconstruct_I = 1'b1; Intra_MB_I = 1'b1; Coded_Block_Pattern_I = 6'h3F;
                @(negedge clock);
                Start_MB_Reconstruct_I = 1'b0;
            end
            wait_done($sformatf("T5 mb%0d", m));
            check_mb($sformatf("T5 mb%0d", m));
            chk($sformatf("T5 mb%0d bank addr", m), addr_bad, 0);
        end
        mon_en = 1'b0;

        // T6: async reset mid-MB; next start reads bank 0 from p=0
        for (int p = 0; p < 384; p++) mem[1024 + p] = 8'hEE;
        got.delete();
        do_start(1'b0, 6'h00);
        k = 0;
        while (!(Pixel_Valid_O && {Pixel_Block_O, Pixel_Index_O} == 9'd100) && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("T6 reach p100", {Pixel_Block_O, Pixel_Index_O}, 9'd100);
        chk("T6 aborted bank data", Pixel_Data_O, 8'hEE);
        #2 resetn = 1'b0;
        #1;
        chk("T6 async valid", Pixel_Valid_O, 1'b0);
        chk("T6 async done", Done_MB_Reconstruct_O, 1'b1);
        chk("T6 async addr", Pred_Addr_O, 11'h000);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int p = 0; p < 384; p++) exp_pix[p] = p & 255;
        got.delete();
        do_start(1'b0, 6'h00);
        wait_done("T6");
        check_mb("T6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
